// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: eight-digit multiplexed seven-segment driver.
// Scans one digit per slot with a leading blank interval; inputs latched once per frame.
module sevenseg_scan_driver #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       sysclk,
    input  logic       sysreset,
    input  logic [7:0] dig0,
    input  logic [7:0] dig1,
    input  logic [7:0] dig2,
    input  logic [7:0] dig3,
    input  logic [7:0] dig4,
    input  logic [7:0] dig5,
    input  logic [7:0] dig6,
    input  logic [7:0] dig7,
    input  logic [3:0] dp_lo,
    input  logic [3:0] dp_hi,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [2:0]    slot;
    logic [4:0]    sh_code [8];
    logic [7:0]    sh_dp;
    logic [4:0]    dig_code [8];
    logic          snap;
    logic          unused_hi;

    assign dig_code[0] = dig0[4:0];
    assign dig_code[1] = dig1[4:0];
    assign dig_code[2] = dig2[4:0];
    assign dig_code[3] = dig3[4:0];
    assign dig_code[4] = dig4[4:0];
    assign dig_code[5] = dig5[4:0];
    assign dig_code[6] = dig6[4:0];
    assign dig_code[7] = dig7[4:0];

    // Upper code bits carry no meaning for the display.
    assign unused_hi = ^{dig0[7:5], dig1[7:5], dig2[7:5], dig3[7:5],
                         dig4[7:5], dig5[7:5], dig6[7:5], dig7[7:5]};

    // Frame start is the only moment software values are taken.
    assign snap = (cnt == '0) && (slot == 3'd0);

    // Active-high gfedcba glyph for a 5-bit digit code.
    function automatic logic [6:0] seg_pattern(input logic [4:0] code);
        logic [6:0] p;
        p = 7'h00;
        case (code)
            5'h00: p = 7'h3F;
            5'h01: p = 7'h06;
            5'h02: p = 7'h5B;
            5'h03: p = 7'h4F;
            5'h04: p = 7'h66;
            5'h05: p = 7'h6D;
            5'h06: p = 7'h7D;
            5'h07: p = 7'h07;
            5'h08: p = 7'h7F;
            5'h09: p = 7'h6F;
            5'h0A: p = 7'h77;
            5'h0B: p = 7'h7C;
            5'h0C: p = 7'h39;
            5'h0D: p = 7'h5E;
            5'h0E: p = 7'h79;
            5'h0F: p = 7'h71;
            5'h11: p = 7'h40;
            5'h12: p = 7'h76;
            5'h13: p = 7'h38;
            5'h14: p = 7'h5C;
            5'h15: p = 7'h73;
            5'h16: p = 7'h3E;
            5'h17: p = 7'h01;
            5'h18: p = 7'h08;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // Slot timing: cnt sweeps one slot, slot steps to the next digit on wrap.
    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            cnt  <= '0;
            slot <= 3'd0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            slot <= slot + 3'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Shadow set: holds the frame's codes and decimal points stable.
    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            for (int i = 0; i < 8; i++) begin
                sh_code[i] <= 5'h10;
            end
            sh_dp <= 8'h00;
        end else if (snap) begin
            for (int i = 0; i < 8; i++) begin
                sh_code[i] <= dig_code[i];
            end
            sh_dp <= {dp_hi, dp_lo};
        end
    end

    // Pin drivers: all dark while blanking, otherwise the current digit.
    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (cnt < CNT_BLANK) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'd1 << slot);
            seg <= ~seg_pattern(sh_code[slot]);
            dp  <= ~sh_dp[slot];
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver: scenario tasks over a cycle scoreboard.
// Anode overlap and blank-gap hazards are watched on every cycle.
module tb_sevenseg_scan_driver;

    localparam int SD = 8;
    localparam int BL = 2;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    logic       sysclk = 1'b0;
    logic       sysreset = 1'b0;
    logic [7:0] dig [8];
    logic [3:0] dp_lo = 4'h0;
    logic [3:0] dp_hi = 4'h0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad = 0;

    out_t       exp_q [$];
    logic [6:0] seg_tab [32];
    int         m_cnt = 0;
    int         m_slot = 0;
    logic [4:0] m_code [8];
    logic [7:0] m_dp = 8'h00;
    int         e_cnt = 0;
    int         e_slot = 0;
    bit         e_valid = 0;

    int         hz_bad = 0;
    int         hz_changes = 0;
    int         ff_run = 0;
    logic [7:0] last_an = 8'hFF;
    bit         seen_lit = 0;

    sevenseg_scan_driver #(
        .SCAN_DIV(SD),
        .BLANK_CYCLES(BL)
    ) dut (
        .sysclk(sysclk),
        .sysreset(sysreset),
        .dig0(dig[0]),
        .dig1(dig[1]),
        .dig2(dig[2]),
        .dig3(dig[3]),
        .dig4(dig[4]),
        .dig5(dig[5]),
        .dig6(dig[6]),
        .dig7(dig[7]),
        .dp_lo(dp_lo),
        .dp_hi(dp_hi),
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    always #5 sysclk = ~sysclk;

    // Hazard watch: one anode at most, and at least BL dark cycles between lit spans.
    always @(negedge sysclk) begin
        if (!$isunknown(an)) begin
            if ($countones(~an) > 1) hz_bad++;
            if (an == 8'hFF) begin
                ff_run++;
            end else begin
                if (seen_lit && (an != last_an || ff_run > 0) && ff_run < BL)
                    hz_bad++;
                if (an != last_an) hz_changes++;
                ff_run = 0;
                last_an = an;
                seen_lit = 1;
            end
        end
    end

    // Advance the reference one clock, queueing the outputs it predicts.
    task automatic cyc();
        out_t e;
        if (!sysreset) begin
            e = {8'hFF, 7'h7F, 1'b1};
            m_cnt = 0;
            m_slot = 0;
            for (int i = 0; i < 8; i++) m_code[i] = 5'h10;
            m_dp = 8'h00;
            e_valid = 0;
        end else begin
            e_valid = 1;
            e_cnt = m_cnt;
            e_slot = m_slot;
            if (m_cnt < BL)
                e = {8'hFF, 7'h7F, 1'b1};
            else
                e = {~(8'h01 << m_slot), ~seg_tab[m_code[m_slot]], ~m_dp[m_slot]};
            if (m_cnt == 0 && m_slot == 0) begin
                for (int i = 0; i < 8; i++) m_code[i] = dig[i][4:0];
                m_dp = {dp_hi, dp_lo};
            end
            if (m_cnt == SD - 1) begin
                m_cnt = 0;
                m_slot = (m_slot + 1) % 8;
            end else begin
                m_cnt++;
            end
        end
        exp_q.push_back(e);
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic test_reset();
        out_t e;
        for (int k = 0; k < 3; k++) begin
            cyc();
            e = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL sb_reset an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         an, seg, dp, e.an, e.seg, e.dp);
            end
        end
        total++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
            bad++;
            $display("FAIL reset_pins an=%h seg=%h dp=%b want FF 7F 1", an, seg, dp);
        end
        sysreset = 1'b1;
        for (int k = 0; k < 64; k++) begin
            cyc();
            e = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL sb_blankframe an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         an, seg, dp, e.an, e.seg, e.dp);
            end
            if (e_valid && e_cnt == 5) begin
                total++;
                if (an !== ~(8'h01 << e_slot) || seg !== 7'h7F) begin
                    bad++;
                    $display("FAIL blank_scan slot=%0d an=%h seg=%h want an=%h seg=7F",
                             e_slot, an, seg, ~(8'h01 << e_slot));
                end
            end
        end
    endtask

    task automatic test_digits();
        out_t e;
        int lit;
        lit = 0;
        for (int i = 0; i < 8; i++) dig[i] = 8'(i);
        dp_lo = 4'b0001;
        dp_hi = 4'b0000;
        for (int k = 0; k < 64; k++) begin
            cyc();
            e = exp_q.pop_front();
            if (an !== 8'hFF) lit++;
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL sb_digits an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         an, seg, dp, e.an, e.seg, e.dp);
            end
            if (e_slot == 0 && e_cnt == 4) begin
                total++;
                if (an !== 8'hFE || seg !== 7'h40 || dp !== 1'b0) begin
                    bad++;
                    $display("FAIL digit0 an=%h seg=%h dp=%b want FE 40 0", an, seg, dp);
                end
            end
            if (e_slot == 3 && e_cnt == 4) begin
                total++;
                if (an !== 8'hF7 || seg !== 7'h30 || dp !== 1'b1) begin
                    bad++;
                    $display("FAIL digit3 an=%h seg=%h dp=%b want F7 30 1", an, seg, dp);
                end
            end
        end
        total++;
        if (lit !== 48) begin
            bad++;
            $display("FAIL drive_cycles got=%0d want=48", lit);
        end
    endtask

    task automatic test_no_tear();
        out_t e;
        for (int k = 0; k < 128; k++) begin
            cyc();
            e = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL sb_tear an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         an, seg, dp, e.an, e.seg, e.dp);
            end
            if (k < 64 && e_slot == 1 && e_cnt == 3) dig[2] = 8'h0E;
            if (e_slot == 2 && e_cnt == 4) begin
                total++;
                if (k < 64 && seg !== 7'h24) begin
                    bad++;
                    $display("FAIL tear_old seg=%h want 24", seg);
                end else if (k >= 64 && seg !== 7'h06) begin
                    bad++;
                    $display("FAIL tear_new seg=%h want 06", seg);
                end
            end
        end
    endtask

    task automatic test_special_codes();
        out_t e;
        dig[4] = 8'h12;
        dig[5] = 8'h1F;
        dig[6] = 8'hE5;
        dig[7] = 8'h18;
        dp_hi = 4'b0010;
        for (int k = 0; k < 64; k++) begin
            cyc();
            e = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL sb_special an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         an, seg, dp, e.an, e.seg, e.dp);
            end
            if (e_cnt == 4 && e_slot == 4) begin
                total++;
                if (seg !== 7'h09 || dp !== 1'b1) begin
                    bad++;
                    $display("FAIL code_H seg=%h dp=%b want 09 1", seg, dp);
                end
            end
            if (e_cnt == 4 && e_slot == 5) begin
                total++;
                if (an !== 8'hDF || seg !== 7'h7F || dp !== 1'b0) begin
                    bad++;
                    $display("FAIL code_unused an=%h seg=%h dp=%b want DF 7F 0", an, seg, dp);
                end
            end
            if (e_cnt == 4 && e_slot == 6) begin
                total++;
                if (seg !== 7'h12) begin
                    bad++;
                    $display("FAIL code_hibits seg=%h want 12", seg);
                end
            end
            if (e_cnt == 4 && e_slot == 7) begin
                total++;
                if (seg !== 7'h77) begin
                    bad++;
                    $display("FAIL code_bottom seg=%h want 77", seg);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        out_t e;
        int n;
        bit hit;
        hit = 0;
        for (int k = 0; k < 64 && !hit; k++) begin
            cyc();
            e = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL sb_premid an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         an, seg, dp, e.an, e.seg, e.dp);
            end
            if (e_slot == 5 && e_cnt == 4) hit = 1;
        end
        total++;
        if (an !== 8'hDF) begin
            bad++;
            $display("FAIL mid_slot5 an=%h want DF", an);
        end
        sysreset = 1'b0;
        dig[0] = 8'h15;
        cyc();
        e = exp_q.pop_front();
        total++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || {an, seg, dp} !== e) begin
            bad++;
            $display("FAIL mid_reset an=%h seg=%h dp=%b want FF 7F 1", an, seg, dp);
        end
        cyc();
        void'(exp_q.pop_front());
        sysreset = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            e = exp_q.pop_front();
            n++;
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL sb_restart an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         an, seg, dp, e.an, e.seg, e.dp);
            end
            if (an !== 8'hFF) break;
        end
        total++;
        if (n !== 3 || an !== 8'hFE || seg !== 7'h0C) begin
            bad++;
            $display("FAIL restart n=%0d an=%h seg=%h want n=3 FE 0C", n, an, seg);
        end
        for (int k = 0; k < 61; k++) begin
            cyc();
            e = exp_q.pop_front();
            total++;
            if ({an, seg, dp} !== e) begin
                bad++;
                $display("FAIL sb_after an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                         an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_hazards();
        total++;
        if (hz_bad !== 0) begin
            bad++;
            $display("FAIL anode_hazard got=%0d want=0", hz_bad);
        end
        total++;
        if (hz_changes < 40) begin
            bad++;
            $display("FAIL anode_activity got=%0d want>=40", hz_changes);
        end
    endtask

    initial begin
        logic [6:0] tab [25];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
                7'h00, 7'h40, 7'h76, 7'h38, 7'h5C, 7'h73, 7'h3E, 7'h01,
                7'h08};
        for (int i = 0; i < 32; i++) seg_tab[i] = (i < 25) ? tab[i] : 7'h00;
        for (int i = 0; i < 8; i++) begin
            dig[i] = 8'h10;
            m_code[i] = 5'h10;
        end
        @(negedge sysclk);
        test_reset();
        test_digits();
        test_no_tear();
        test_special_codes();
        test_reset_mid();
        test_hazards();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
